// File: rtl/uart_hexdump_fmt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_hexdump_fmt_pkg : shared characters, FSM states and hex helper.  rev 1.0
// ----------------------------------------------------------------------------
package uart_hexdump_fmt_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_COLON = 4'd2,
    S_FETCH = 4'd3,
    S_SPACE = 4'd4,
    S_HI    = 4'd5,
    S_LO    = 4'd6,
    S_CR    = 4'd7,
    S_LF    = 4'd8
  } state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_hexdump_fmt_hex_nibble_ascii.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hex_nibble_ascii : 4-bit value to uppercase ASCII hex digit.  rev 1.0
// ----------------------------------------------------------------------------
module hex_nibble_ascii
  import uart_hexdump_fmt_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = nibble_to_ascii(nibble_i);

endmodule
`default_nettype wire

// File: rtl/uart_hexdump_fmt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_hexdump_fmt : RAM block to baud-paced ASCII hex dump text.  rev 1.0
// ----------------------------------------------------------------------------
module uart_hexdump_fmt
  import uart_hexdump_fmt_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int BYTES_PER_LINE = 8,
  parameter int CHAR_GAP       = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  baud_x1,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [8:0]            length,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  output logic [7:0]            data,
  output logic                  data_strobe
);

  localparam int                    DIGITS    = ADDR_WIDTH / 4;
  localparam logic [3:0]            GAP_LAST  = 4'(CHAR_GAP - 1);
  localparam logic [3:0]            DIG_LAST  = 4'(DIGITS - 1);
  localparam logic [4:0]            LINE_LAST = 5'(BYTES_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                state_q;
  logic                  sent_q;
  logic [3:0]            gap_q;
  logic [3:0]            dig_q;
  logic [4:0]            line_q;
  logic [8:0]            rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q;
  logic [7:0]            byte_q;
  logic                  busy_q;
  logic                  mem_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            data_q;
  logic                  strobe_q;

  logic [3:0]            nib_d;
  logic [7:0]            hex_d;
  logic [7:0]            char_d;
  logic                  is_char_d;
  logic                  slot_d;
  logic                  emit_d;

  always_comb begin
    nib_d = addr_sh_q[ADDR_WIDTH-1 -: 4];
    if (state_q == S_HI) begin
      nib_d = byte_q[7:4];
    end else if (state_q == S_LO) begin
      nib_d = byte_q[3:0];
    end
  end

  hex_nibble_ascii u_hex (
    .nibble_i (nib_d),
    .ascii_o  (hex_d)
  );

  always_comb begin
    char_d    = hex_d;
    is_char_d = 1'b1;
    case (state_q)
      S_COLON: char_d = ASCII_COLON;
      S_SPACE: char_d = ASCII_SPACE;
      S_CR:    char_d = ASCII_CR;
      S_LF:    char_d = ASCII_LF;
      S_IDLE,
      S_FETCH: is_char_d = 1'b0;
      default: char_d = hex_d;
    endcase
  end

  // A slot opens on the tick that completes CHAR_GAP ticks since the last rise;
  // the counter saturates there so an idle formatter is always ready to send.
  assign slot_d = baud_x1 && (gap_q == GAP_LAST);
  assign emit_d = slot_d && is_char_d && !sent_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sent_q     <= 1'b0;
      gap_q      <= '0;
      dig_q      <= '0;
      line_q     <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      addr_sh_q  <= '0;
      byte_q     <= '0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;

      if (baud_x1) begin
        strobe_q <= emit_d;
        if (emit_d) begin
          gap_q <= '0;
        end else if (gap_q != GAP_LAST) begin
          gap_q <= gap_q + 4'd1;
        end
      end

      if (emit_d) begin
        data_q <= char_d;
        sent_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start && (length != 9'd0)) begin
            busy_q    <= 1'b1;
            addr_q    <= start_addr;
            addr_sh_q <= start_addr;
            rem_q     <= length;
            gap_q     <= GAP_LAST;
            dig_q     <= '0;
            line_q    <= '0;
            sent_q    <= 1'b0;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (sent_q) begin
            sent_q    <= 1'b0;
            addr_sh_q <= addr_sh_q << 4;
            if (dig_q == DIG_LAST) begin
              state_q <= S_COLON;
            end else begin
              dig_q <= dig_q + 4'd1;
            end
          end
        end
        S_COLON: begin
          if (sent_q) begin
            sent_q     <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_q;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // First cycle: RAM samples the request. Second cycle: read data valid.
          if (!sent_q) begin
            sent_q <= 1'b1;
          end else begin
            sent_q  <= 1'b0;
            byte_q  <= mem_data;
            state_q <= S_SPACE;
          end
        end
        S_SPACE: begin
          if (sent_q) begin
            sent_q  <= 1'b0;
            state_q <= S_HI;
          end
        end
        S_HI: begin
          if (sent_q) begin
            sent_q  <= 1'b0;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (sent_q) begin
            sent_q <= 1'b0;
            rem_q  <= rem_q - 9'd1;
            addr_q <= addr_q + ADDR_ONE;
            line_q <= line_q + 5'd1;
            if ((rem_q == 9'd1) || ((line_q + 5'd1) == LINE_LAST)) begin
              state_q <= S_CR;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= addr_q + ADDR_ONE;
              state_q    <= S_FETCH;
            end
          end
        end
        S_CR: begin
          if (sent_q) begin
            sent_q  <= 1'b0;
            state_q <= S_LF;
          end
        end
        S_LF: begin
          if (sent_q) begin
            if (rem_q == 9'd0) begin
              if (slot_d) begin
                sent_q  <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              sent_q    <= 1'b0;
              addr_sh_q <= addr_q;
              dig_q     <= '0;
              line_q    <= '0;
              state_q   <= S_ADDR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign data        = data_q;
  assign data_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_hexdump_fmt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_hexdump_fmt : randomized dumps checked against a text-level model.
// ----------------------------------------------------------------------------
module tb_uart_hexdump_fmt;

  localparam int AW  = 16;
  localparam int BPL = 8;
  localparam int GAP = 12;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          baud_x1    = 1'b0;
  logic          start      = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [8:0]    length     = '0;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data   = '0;
  logic [7:0]    data;
  logic          data_strobe;

  uart_hexdump_fmt #(
    .ADDR_WIDTH     (AW),
    .BYTES_PER_LINE (BPL),
    .CHAR_GAP       (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_x1     (baud_x1),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .data        (data),
    .data_strobe (data_strobe)
  );

  always #5 clk = ~clk;

  int baud_div = 3;
  int baud_cnt = 0;
  always @(posedge clk) begin
    if (baud_cnt >= baud_div - 1) begin
      baud_cnt <= 0;
      baud_x1  <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 1;
      baud_x1  <= 1'b0;
    end
  end

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_rd) mem_data <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected text and read addresses, derived directly from the line format.
  logic [7:0] exp_q[$];
  int         exp_rd[$];

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic void build_expected(input int sa, input int len);
    exp_q.delete();
    exp_rd.delete();
    for (int i = 0; i < len; i++) begin
      int a;
      a = (sa + i) & 'hFFFF;
      if (i % BPL == 0) begin
        for (int d = AW/4 - 1; d >= 0; d--) exp_q.push_back(hexc((a >> (4*d)) & 15));
        exp_q.push_back(8'h3A);
      end
      exp_rd.push_back(a);
      exp_q.push_back(8'h20);
      exp_q.push_back(hexc(int'(ram[a]) >> 4));
      exp_q.push_back(hexc(int'(ram[a]) & 15));
      if ((i % BPL == BPL - 1) || (i == len - 1)) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endfunction

  // Output monitor, sampled on the falling edge.
  logic [7:0] cap_q[$];
  int         rd_q[$];
  int         tick_cnt    = 0;
  int         last_rise   = 0;
  int         busy_ticks  = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_busy   = 1'b0;
  logic [7:0] prev_data   = '0;
  bit         mon_en      = 1'b0;
  bit         busy_seen   = 1'b0;

  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (data_strobe && !prev_strobe) begin
        if (cap_q.size() == 0) chk("first_rise_ticks", busy_ticks, 1);
        else                   chk("rise_spacing", tick_cnt - last_rise, GAP);
        cap_q.push_back(data);
        last_rise = tick_cnt;
      end else if (!data_strobe && prev_strobe) begin
        chk("strobe_width", tick_cnt - last_rise, 1);
      end
      if ((data != prev_data) && !(data_strobe && !prev_strobe))
        chk("data_stable", (tick_cnt - last_rise) >= GAP, 1);
      if (mem_rd) rd_q.push_back(int'(mem_addr));
      if (!busy && prev_busy) chk("busy_fall_ticks", tick_cnt - last_rise, GAP);
      if (busy) busy_seen = 1'b1;
    end
    if (baud_x1) tick_cnt++;
    if (!busy) busy_ticks = 0;
    else if (baud_x1) busy_ticks++;
    prev_strobe = data_strobe;
    prev_busy   = busy;
    prev_data   = data;
  end

  task automatic pulse_start(input int sa, input int len);
    @(posedge clk); #1;
    start_addr = AW'(sa);
    length     = 9'(len);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = AW'($urandom);
    length     = 9'($urandom_range(1, 256));
  endtask

  task automatic run_dump(input int sa, input int len, input int div, input bit poke);
    int lines, nchar, budget, cyc;
    baud_div = div;
    build_expected(sa, len);
    cap_q.delete();
    rd_q.delete();
    pulse_start(sa, len);
    chk("busy_after_accept", busy, 1);
    lines  = (len + BPL - 1) / BPL;
    nchar  = lines * (AW/4 + 3) + 3 * len;
    budget = (nchar + 2) * GAP * div + 100;
    cyc    = 0;
    while (busy && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc % 97 == 0);
    end
    start = 1'b0;
    chk("dump_done_in_budget", busy, 0);
    if (busy) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
    chk("char_count", cap_q.size(), nchar);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 8'h00;
      chk($sformatf("char[%0d]", i), g, exp_q[i]);
      if (g != exp_q[i]) break;
    end
    chk("mem_rd_count", rd_q.size(), len);
    for (int i = 0; i < exp_rd.size(); i++) begin
      int g;
      g = (i < rd_q.size()) ? rd_q[i] : -1;
      chk($sformatf("mem_addr[%0d]", i), g, exp_rd[i]);
      if (g != exp_rd[i]) break;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h0200] = 8'hA5;
    for (int i = 0; i < 9; i++) ram[16'h0010 + i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data", data, 0);
    chk("rst_strobe", data_strobe, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (4) @(posedge clk);

    run_dump(16'h0200, 1, 3, 1'b0);
    run_dump(16'h0010, 9, 2, 1'b0);
    run_dump(16'hFFFE, 4, 2, 1'b1);

    // Zero length with start held: must stay idle and silent.
    cap_q.delete();
    busy_seen = 1'b0;
    @(posedge clk); #1;
    start_addr = AW'($urandom);
    length     = 9'd0;
    start      = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    start = 1'b0;
    chk("len0_busy_seen", busy_seen, 0);
    chk("len0_strobes", cap_q.size(), 0);

    // Reset during the 5th character, then a clean full dump.
    baud_div = 2;
    cap_q.delete();
    pulse_start(16'h1234, 12);
    cyc = 0;
    while (cap_q.size() < 5 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_5th_char", cap_q.size() >= 5, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_data", data, 0);
    chk("midrst_strobe", data_strobe, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    run_dump(16'h1234, 12, 2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      int sa;
      sa = (k == 0) ? int'($urandom_range(65520, 65535)) : int'($urandom_range(0, 65535));
      run_dump(sa, int'($urandom_range(1, 24)), int'($urandom_range(1, 3)), 1'($urandom));
    end

    run_dump(int'($urandom_range(0, 65535)), 256, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
